// File: rtl/stream_accum.sv
// Purpose: per-frame prefix-sum (running sum mod 2^DW) AXI-Stream stage; frames are cfg_len words long.
// Latency: 1 cycle from an accepted input beat to the registered output beat.
// Backpressure: input is ready only in RUN with cfg_en=1 and the output register free or draining, giving 1 word/cycle.
//
// Ports: AXIS_ACLK/AXIS_ARESETN clock and async active-low reset; cfg_en/cfg_len run control and frame length;
//        S_AXIS_* input stream (TSTRB/TLAST ignored); M_AXIS_* output stream of running sums, TLAST on the
//        last word of each frame; busy (not IDLE), done (one-cycle pulse per completed frame), frame_cnt.
module stream_accum #(
    parameter int DW = 32,
    parameter int LW = 9
) (
    input  logic            AXIS_ACLK,
    input  logic            AXIS_ARESETN,
    input  logic            cfg_en,
    input  logic [LW-1:0]   cfg_len,
    input  logic            S_AXIS_TVALID,
    input  logic [DW-1:0]   S_AXIS_TDATA,
    input  logic [DW/8-1:0] S_AXIS_TSTRB,
    input  logic            S_AXIS_TLAST,
    output logic            S_AXIS_TREADY,
    output logic            M_AXIS_TVALID,
    output logic [DW-1:0]   M_AXIS_TDATA,
    output logic [DW/8-1:0] M_AXIS_TSTRB,
    output logic            M_AXIS_TLAST,
    input  logic            M_AXIS_TREADY,
    output logic            busy,
    output logic            done,
    output logic [15:0]     frame_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state, state_d;
    logic [DW-1:0]   acc;
    logic [LW-1:0]   wcnt;
    logic [LW-1:0]   len_r;

    logic            out_free;
    logic            accept;
    logic            out_take;
    logic            last_beat;
    logic            start_ok;
    logic [DW-1:0]   sum;
    logic            load;      // start a new frame: capture cfg_len, zero the sum
    logic            clr;       // abandon or finish: zero the sum and word count
    logic            done_d;

    // Framing comes from the length register; the upstream TLAST/TSTRB carry nothing useful.
    logic unused_in;
    assign unused_in = &{1'b0, S_AXIS_TSTRB, S_AXIS_TLAST};

    assign out_free      = ~M_AXIS_TVALID | M_AXIS_TREADY;
    assign S_AXIS_TREADY = (state == RUN) & cfg_en & out_free;
    assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;
    assign out_take      = M_AXIS_TVALID & M_AXIS_TREADY;
    assign last_beat     = (wcnt == len_r - LW'(1));
    assign start_ok      = cfg_en & (cfg_len != '0);
    assign sum           = acc + S_AXIS_TDATA;
    assign M_AXIS_TSTRB  = '1;
    assign busy          = (state != IDLE);

    always_comb begin
        state_d = state;
        load    = 1'b0;
        clr     = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (accept && last_beat) begin
                    state_d = DRAIN;
                end else if (!cfg_en && out_free) begin
                    // Abort: leave only once any pending output beat has been handed over.
                    state_d = IDLE;
                    clr     = 1'b1;
                end
            end
            DRAIN: begin
                if (out_take) begin
                    done_d = 1'b1;
                    if (start_ok) begin
                        state_d = RUN;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        clr     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                clr     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            acc           <= '0;
            wcnt          <= '0;
            len_r         <= '0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
            done          <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            done <= done_d;
            if (done_d) begin
                frame_cnt <= frame_cnt + 16'd1;
            end

            if (load) begin
                len_r <= cfg_len;
                acc   <= '0;
                wcnt  <= '0;
            end else if (clr) begin
                acc   <= '0;
                wcnt  <= '0;
            end else if (accept) begin
                acc   <= sum;
                wcnt  <= wcnt + LW'(1);
            end

            // Output register: a new beat overwrites in the same cycle the old one drains.
            if (accept) begin
                M_AXIS_TVALID <= 1'b1;
                M_AXIS_TDATA  <= sum;
                M_AXIS_TLAST  <= last_beat;
            end else if (M_AXIS_TREADY) begin
                M_AXIS_TVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_accum.sv
// Purpose: randomized and directed check of stream_accum against a frame-level prefix-sum model.
// Latency: n/a (bench).
// Backpressure: downstream ready is randomized, patterned or held by the stimulus process.
module tb_stream_accum;

    localparam int DW = 32;
    localparam int LW = 9;

    logic            AXIS_ACLK = 1'b0;
    logic            AXIS_ARESETN;
    logic            cfg_en;
    logic [LW-1:0]   cfg_len;
    logic            S_AXIS_TVALID;
    logic [DW-1:0]   S_AXIS_TDATA;
    logic [DW/8-1:0] S_AXIS_TSTRB;
    logic            S_AXIS_TLAST;
    logic            S_AXIS_TREADY;
    logic            M_AXIS_TVALID;
    logic [DW-1:0]   M_AXIS_TDATA;
    logic [DW/8-1:0] M_AXIS_TSTRB;
    logic            M_AXIS_TLAST;
    logic            M_AXIS_TREADY;
    logic            busy;
    logic            done;
    logic [15:0]     frame_cnt;

    stream_accum #(.DW(DW), .LW(LW)) dut (
        .AXIS_ACLK     (AXIS_ACLK),
        .AXIS_ARESETN  (AXIS_ARESETN),
        .cfg_en        (cfg_en),
        .cfg_len       (cfg_len),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TSTRB  (S_AXIS_TSTRB),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TSTRB  (M_AXIS_TSTRB),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .busy          (busy),
        .done          (done),
        .frame_cnt     (frame_cnt)
    );

    always #5 AXIS_ACLK = ~AXIS_ACLK;

    int              total = 0;
    int              bad   = 0;
    logic [DW:0]     exp_q[$];      // {data, last}
    logic [DW-1:0]   stim_q[$];
    int              exp_frames = 0;
    int              sink_mode  = 1;  // 0 random, 1 held by stimulus, 3 pattern 1,0,0
    int              gap_max    = 0;
    int              cyc        = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Downstream sink
    always @(negedge AXIS_ACLK) begin
        cyc++;
        if (sink_mode == 0)      M_AXIS_TREADY = ($urandom_range(0, 99) < 70);
        else if (sink_mode == 3) M_AXIS_TREADY = (cyc % 3 == 0);
    end

    // Monitor / scoreboard
    logic        exp_done = 1'b0;
    logic        held_vld = 1'b0;
    logic [DW:0] held;
    always @(negedge AXIS_ACLK) begin
        #1;
        if (AXIS_ARESETN) begin
            chk("done_pulse", done, exp_done);
            exp_done = 1'b0;
            if (held_vld && M_AXIS_TVALID)
                chk("stall_stable", {M_AXIS_TDATA, M_AXIS_TLAST}, held);
            if (M_AXIS_TVALID && !M_AXIS_TREADY)
                chk("s_rdy_when_held", S_AXIS_TREADY, 1'b0);
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_beat got=%0h want=none", M_AXIS_TDATA);
                end else begin
                    chk("beat_data_last", {M_AXIS_TDATA, M_AXIS_TLAST}, exp_q.pop_front());
                    chk("tstrb", M_AXIS_TSTRB, {(DW/8){1'b1}});
                end
                exp_done = M_AXIS_TLAST;
            end
            held_vld = M_AXIS_TVALID && !M_AXIS_TREADY;
            held     = {M_AXIS_TDATA, M_AXIS_TLAST};
        end else begin
            exp_done = 1'b0;
            held_vld = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rword();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF - $urandom_range(0, 3);
            1:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic beat(input logic [DW-1:0] d);
        int t = 0;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = 1'($urandom);
        S_AXIS_TSTRB  = 4'($urandom);
        #1;
        while (!S_AXIS_TREADY && t <= 300) begin
            t++;
            @(negedge AXIS_ACLK); #1;
        end
        if (t > 300) begin
            total++; bad++;
            $display("FAIL beat_timeout got=%0d want<=300", t);
        end
        @(negedge AXIS_ACLK);
        S_AXIS_TVALID = 1'b0;
    endtask

    // Model: expected outputs are the prefix sums of this frame's words; a complete frame ends with last.
    task automatic run_frame(input int len, input bit keep_en, input bit garble);
        logic [DW-1:0] s = '0;
        cfg_len = LW'(len);
        cfg_en  = 1'b1;
        for (int i = 0; i < stim_q.size(); i++) begin
            s = s + stim_q[i];
            exp_q.push_back({s, (i == len - 1)});
        end
        if (stim_q.size() == len) exp_frames++;
        for (int i = 0; i < stim_q.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge AXIS_ACLK);
            beat(stim_q[i]);
            if (garble && i == 0) cfg_len = LW'($urandom_range(1, 511));
        end
        if (!keep_en) cfg_en = 1'b0;
    endtask

    // Returns at negedge+1 with scoreboard empty and output idle.
    task automatic wait_drain(input string nm);
        int t = 0;
        do begin
            @(negedge AXIS_ACLK); #1;
            t++;
        end while ((exp_q.size() != 0 || M_AXIS_TVALID) && t < 3000);
        if (t >= 3000) begin
            total++; bad++;
            $display("FAIL %s_drain_timeout got=%0d want<3000", nm, exp_q.size());
        end
        @(negedge AXIS_ACLK); #1;
        chk({nm, "_frame_cnt"}, frame_cnt, 16'(exp_frames));
        chk({nm, "_busy"}, busy, 1'b0);
        @(negedge AXIS_ACLK);
    endtask

    initial begin
        AXIS_ARESETN  = 1'b0;
        cfg_en        = 1'b0;
        cfg_len       = '0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TSTRB  = '0;
        S_AXIS_TLAST  = 1'b0;
        M_AXIS_TREADY = 1'b1;
        repeat (2) @(negedge AXIS_ACLK);
        #1;
        chk("rst_tvalid", M_AXIS_TVALID, 1'b0);
        chk("rst_tdata", M_AXIS_TDATA, '0);
        chk("rst_tlast", M_AXIS_TLAST, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_frame_cnt", frame_cnt, '0);
        chk("rst_busy", busy, 1'b0);
        @(negedge AXIS_ACLK);
        AXIS_ARESETN = 1'b1;

        // Basic frame 1,2,3,4 -> 1,3,6,10
        sink_mode = 1; M_AXIS_TREADY = 1'b1; gap_max = 0;
        stim_q = {};
        for (int i = 1; i <= 4; i++) stim_q.push_back(DW'(i));
        run_frame(4, 0, 0);
        wait_drain("basic");

        // Same frame, downstream ready 1,0,0 pattern
        sink_mode = 3;
        run_frame(4, 0, 0);
        wait_drain("stall");

        // Wraparound
        sink_mode = 0; gap_max = 1;
        stim_q = {};
        stim_q.push_back(32'hFFFF_FFFF);
        stim_q.push_back(32'h0000_0002);
        run_frame(2, 0, 0);
        wait_drain("wrap");

        // Back-to-back frames of 3 with cfg_en held
        sink_mode = 1; M_AXIS_TREADY = 1'b1; gap_max = 0;
        stim_q = {};
        for (int i = 0; i < 3; i++) stim_q.push_back(DW'(5));
        run_frame(3, 1, 0);
        run_frame(3, 0, 0);
        wait_drain("b2b");

        // Abort after 3 of 8 beats with the third output stalled
        stim_q = {};
        for (int i = 0; i < 3; i++) stim_q.push_back(DW'(5));
        run_frame(8, 1, 0);
        M_AXIS_TREADY = 1'b0;
        cfg_en        = 1'b0;
        S_AXIS_TVALID = 1'b1;
        #1;
        chk("abort_s_rdy", S_AXIS_TREADY, 1'b0);
        chk("abort_pending", {M_AXIS_TVALID, M_AXIS_TDATA}, {1'b1, 32'd15});
        repeat (3) @(negedge AXIS_ACLK);
        S_AXIS_TVALID = 1'b0;
        M_AXIS_TREADY = 1'b1;
        wait_drain("abort");
        stim_q = {};
        for (int i = 0; i < 3; i++) stim_q.push_back(rword());
        run_frame(3, 0, 0);
        wait_drain("after_abort");

        // Randomized frames, including single-beat and maximum-length frames
        sink_mode = 0; gap_max = 2;
        for (int k = 0; k < 25; k++) begin
            int len;
            bit keep;
            if (k == 10)                           len = 511;
            else if ($urandom_range(0, 9) < 7)     len = $urandom_range(1, 12);
            else                                   len = $urandom_range(13, 40);
            stim_q = {};
            for (int i = 0; i < len; i++) stim_q.push_back(rword());
            keep = (k != 24) && ($urandom_range(0, 3) != 0);
            run_frame(len, keep, 1'($urandom));
        end
        wait_drain("random");

        // Reset mid-frame with an output beat in flight
        sink_mode = 1; M_AXIS_TREADY = 1'b0; gap_max = 0;
        cfg_len = LW'(8); cfg_en = 1'b1;
        beat(32'd7);
        AXIS_ARESETN = 1'b0;
        #1;
        chk("midrst_tvalid", M_AXIS_TVALID, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_frame_cnt", frame_cnt, '0);
        exp_frames = 0;
        cfg_en = 1'b0;
        @(negedge AXIS_ACLK);
        AXIS_ARESETN = 1'b1;

        // Zero length keeps the block idle
        cfg_len = '0; cfg_en = 1'b1; S_AXIS_TVALID = 1'b1; M_AXIS_TREADY = 1'b1;
        repeat (3) @(negedge AXIS_ACLK);
        #1;
        chk("len0_busy", busy, 1'b0);
        chk("len0_s_rdy", S_AXIS_TREADY, 1'b0);
        chk("len0_tvalid", M_AXIS_TVALID, 1'b0);
        @(negedge AXIS_ACLK);
        S_AXIS_TVALID = 1'b0; cfg_en = 1'b0;
        repeat (2) @(negedge AXIS_ACLK);
        #1;
        chk("leftover_expected", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_accum.md
Name: stream_accum

Overview:
- AXI-Stream processing stage that consumes the word stream read out of the DMA test memory block and returns a transformed stream to that block's stream-write port.
- Each frame of cfg_len words becomes a stream of running sums (prefix sums, modulo 2^DW).
- Output TLAST marks the last word of the frame.
- Frame boundaries come from the length register, not TLAST: the upstream master holds TLAST at 0.

Parameters:
- DW, 32, data width of both streams.
- LW, 9, width of the frame-length and word counters (matches the 9-bit stream size register).

Ports:
- AXIS_ACLK  in  1  single clock for all logic.
- AXIS_ARESETN  in  1  asynchronous active-low reset.
- cfg_en  in  1  level; 1 = run frames, 0 = stop after the current beat drains.
- cfg_len  in  LW  words per frame; sampled on frame start.
- S_AXIS_TVALID  in  1  input beat valid.
- S_AXIS_TDATA  in  DW  input data.
- S_AXIS_TSTRB  in  DW/8  ignored.
- S_AXIS_TLAST  in  1  ignored.
- S_AXIS_TREADY  out  1  input accept.
- M_AXIS_TVALID  out  1  output beat valid.
- M_AXIS_TDATA  out  DW  running sum.
- M_AXIS_TSTRB  out  DW/8  constant all ones.
- M_AXIS_TLAST  out  1  last beat of the frame.
- M_AXIS_TREADY  in  1  downstream accept.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a frame completes normally.
- frame_cnt  out  16  completed-frame count; wraps at 2^16.

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, acc=0, wcnt=0, len_r=0, M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, done=0, frame_cnt=0.
- States:
  - IDLE -> RUN when cfg_en=1 and cfg_len!=0. On that edge: len_r<=cfg_len, acc<=0, wcnt<=0.
  - With cfg_len==0 the block stays in IDLE.
- Input accept: S_AXIS_TREADY = (state==RUN) & cfg_en & (~M_AXIS_TVALID | M_AXIS_TREADY). A beat is accepted when S_AXIS_TVALID & S_AXIS_TREADY.
- Per accepted beat, registered at the next edge (latency 1):
  - sum = acc + S_AXIS_TDATA, truncated to DW bits.
  - acc<=sum, M_AXIS_TDATA<=sum, M_AXIS_TVALID<=1.
  - M_AXIS_TLAST<=(wcnt==len_r-1); wcnt<=wcnt+1.
- Output register:
  - Cleared (TVALID<=0) on M_AXIS_TREADY when no new beat is accepted in the same cycle.
  - Simultaneous drain and accept is full throughput, 1 word/cycle.
  - TVALID, TDATA and TLAST are held stable while TVALID=1 and TREADY=0.
- Last beat accepted (wcnt==len_r-1) -> state DRAIN; the input is closed.
- DRAIN: when the output beat is taken (TVALID & TREADY), then:
  - done=1 for one cycle and frame_cnt+1.
  - If cfg_en=1 and cfg_len!=0: back to RUN with new len_r, acc=0, wcnt=0, with no idle cycle required beyond the drain.
  - Otherwise -> IDLE.
- Abort: cfg_en=0 while in RUN.
  - TREADY drops combinationally.
  - Any pending output beat stays valid until taken (AXIS rule).
  - Then -> IDLE with no done pulse, frame_cnt unchanged, acc/wcnt cleared.
  - A partial frame is discarded; the next frame restarts from zero.
- cfg_len changes mid-frame have no effect; only len_r is used.
- Reset asserted mid-frame: all state is cleared immediately; the in-flight output beat is lost.
- len_r=1: every frame is a single beat with TLAST=1 and data equal to the input word.
- wcnt and len_r are LW bits; maximum frame length is 2^LW-1 (511).

Test Plan:
- cfg_len=4, cfg_en=1, inputs 1,2,3,4, TREADY=1 -> outputs 1,3,6,10; TLAST only on 10; done pulse one cycle after the 10 handshake; frame_cnt=1.
- Same frame with TREADY toggling 1,0,0,1,... -> identical data order; TDATA/TLAST stable during stalls; S_AXIS_TREADY=0 whenever the output is held.
- Inputs 32'hFFFF_FFFF then 32'h0000_0002, cfg_len=2 -> outputs FFFF_FFFF, 0000_0001 (wrap); TLAST on the second.
- cfg_len=3, cfg_en held 1, six inputs of value 5 -> 5,10,15 then 5,10,15; TLAST on both 15s; frame_cnt=2; no dropped beats between frames.
- cfg_len=8; drop cfg_en after 3 beats with the 3rd output stalled -> 15 still delivered when TREADY=1; no done; frame_cnt unchanged; busy=0 afterwards; a new frame starts from acc=0.
- Assert AXIS_ARESETN=0 mid-frame -> M_AXIS_TVALID=0, busy=0, frame_cnt=0 immediately; cfg_len=0 with cfg_en=1 -> block stays IDLE, TREADY=0.
